clint: RTL and testbench

Machine-mode core-local interruptor: the memory-side responder for the core's data-memory request/response interface. It decodes a 64 KiB window, holds the `msip`, `mtimecmp` and `mtime` registers, runs the 64-bit free-running timer, and drives the `msip`/`mtip` interrupt lines into the CSR unit's `mip` bits.

---
 rtl/clint.sv | 193 +++++++++++++++++++
 tb/tb_clint.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// Machine-mode core-local interruptor: msip/mtimecmp/mtime registers behind a 64 KiB data-memory window.
// Latency: request captured at edge N, mem_ready high for the single cycle N+1; one access per 2 cycles.
// Backpressure: none; the initiator holds mem_in until mem_ready, and requests are only sampled in IDLE.

package clint_pkg;

  localparam logic [1:0] M_MODE = 2'b11;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

module clint
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned CLK_DIV   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  mem_in,
  output mem_out_type mem_out,
  output logic        msip,
  output logic        mtip
);

  // Register offsets inside the window.
  localparam logic [15:0] OFF_MSIP      = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP  = 16'h4000;
  localparam logic [15:0] OFF_MTIMECMPH = 16'h4004;
  localparam logic [15:0] OFF_MTIME     = 16'hBFF8;
  localparam logic [15:0] OFF_MTIMEH    = 16'hBFFC;

  // Last prescaler value before it wraps and mtime advances.
  localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      state_q;
  logic        ready_q;
  logic        error_q;
  logic [31:0] rdata_q;

  logic        msip_q, msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] mtime_q, mtime_d;
  logic [15:0] presc_q, presc_d;
  logic        mtip_q;

  logic [15:0] offset;
  logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
  logic        mapped;
  logic        req_err;
  logic        capture;
  logic        wr_en;
  logic        presc_wrap;
  logic [31:0] rd_dat;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_dat,
                                              input logic [31:0] new_dat,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_dat;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_dat[8*i +: 8];
    end
    return res;
  endfunction

  assign offset      = mem_in.mem_addr[15:0];
  assign sel_msip    = (offset == OFF_MSIP);
  assign sel_cmp_lo  = (offset == OFF_MTIMECMP);
  assign sel_cmp_hi  = (offset == OFF_MTIMECMPH);
  assign sel_time_lo = (offset == OFF_MTIME);
  assign sel_time_hi = (offset == OFF_MTIMEH);
  assign mapped      = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;

  // Any failing check turns the access into an error with no side effects.
  assign req_err = (mem_in.mem_addr[1:0] != 2'b00)
                 | ~mapped
                 | (mem_in.mem_addr[31:16] != BASE_ADDR[31:16])
                 | mem_in.mem_instr
                 | (mem_in.mem_mode != M_MODE);

  assign capture = (state_q == IDLE) && mem_in.mem_valid;
  assign wr_en   = capture && !req_err && (mem_in.mem_wstrb != 4'b0000);

  assign presc_wrap = (presc_q == PRESC_MAX);

  // Read mux over the pre-edge register values.
  always_comb begin
    rd_dat = '0;
    if (sel_msip)         rd_dat = {31'b0, msip_q};
    else if (sel_cmp_lo)  rd_dat = mtimecmp_q[31:0];
    else if (sel_cmp_hi)  rd_dat = mtimecmp_q[63:32];
    else if (sel_time_lo) rd_dat = mtime_q[31:0];
    else if (sel_time_hi) rd_dat = mtime_q[63:32];
  end

  // Next-state for the prescaler, timer and software-writable registers.
  always_comb begin
    presc_d    = presc_wrap ? 16'd0 : presc_q + 16'd1;
    mtime_d    = presc_wrap ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_en) begin
      if (sel_msip && mem_in.mem_wstrb[0]) msip_d = mem_in.mem_wdata[0];
      if (sel_cmp_lo)
        mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], mem_in.mem_wdata, mem_in.mem_wstrb);
      if (sel_cmp_hi)
        mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], mem_in.mem_wdata, mem_in.mem_wstrb);
      // A software write to mtime wins over the tick; the other half stays as it was.
      if (sel_time_lo)
        mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], mem_in.mem_wdata, mem_in.mem_wstrb)};
      if (sel_time_hi)
        mtime_d = {merge_bytes(mtime_q[63:32], mem_in.mem_wdata, mem_in.mem_wstrb), mtime_q[31:0]};
    end
  end

  // Timer, compare and msip state; mtip is a registered compare of current values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
    end
  end

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            error_q <= req_err;
            rdata_q <= req_err ? 32'd0 : rd_dat;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          error_q <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          error_q <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  assign mem_out.mem_ready = ready_q;
  assign mem_out.mem_error = error_q;
  assign mem_out.mem_rdata = rdata_q;
  assign msip              = msip_q;
  assign mtip              = mtip_q;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint with default parameters (BASE_ADDR 0x0200_0000, CLK_DIV 1).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-derived from the edge count of each step.

module tb_clint;
  import clint_pkg::*;

  logic        clock;
  logic        reset;
  mem_in_type  mem_in;
  mem_out_type mem_out;
  logic        msip;
  logic        mtip;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  logic [31:0] rsp_dat;
  logic        rsp_err;

  clint dut (
    .clock  (clock),
    .reset  (reset),
    .mem_in (mem_in),
    .mem_out(mem_out),
    .msip   (msip),
    .mtip   (mtip)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request at a falling edge; returns at the falling edge of the response cycle.
  task automatic req_start(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic instr, input logic [1:0] mode);
    mem_in.mem_valid = 1'b1;
    mem_in.mem_instr = instr;
    mem_in.mem_mode  = mode;
    mem_in.mem_addr  = addr;
    mem_in.mem_wdata = wdata;
    mem_in.mem_wstrb = strb;
    @(posedge clock);
    @(negedge clock);
    check({tag, "_ready"}, {31'b0, mem_out.mem_ready}, 32'd1);
    rsp_dat = mem_out.mem_rdata;
    rsp_err = mem_out.mem_error;
    mem_in.mem_valid = 1'b0;
  endtask

  // One cycle later mem_ready must have dropped again.
  task automatic req_end(input string tag);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_ready_drop"}, {31'b0, mem_out.mem_ready}, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    req_start(tag, addr, 32'd0, 4'h0, 1'b0, M_MODE);
    check({tag, "_rdata"}, rsp_dat, exp);
    check({tag, "_err"}, {31'b0, rsp_err}, 32'd0);
    req_end(tag);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] dat,
                    input logic [3:0] strb);
    req_start(tag, addr, dat, strb, 1'b0, M_MODE);
    check({tag, "_err"}, {31'b0, rsp_err}, 32'd0);
    req_end(tag);
  endtask

  task automatic bad(input string tag, input logic [31:0] addr, input logic [31:0] dat,
                     input logic [3:0] strb, input logic instr, input logic [1:0] mode);
    req_start(tag, addr, dat, strb, instr, mode);
    check({tag, "_err"}, {31'b0, rsp_err}, 32'd1);
    check({tag, "_rdata"}, rsp_dat, 32'd0);
    req_end(tag);
  endtask

  initial begin
    mem_in = '0;
    reset  = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_ready", {31'b0, mem_out.mem_ready}, 32'd0);
    check("rst_error", {31'b0, mem_out.mem_error}, 32'd0);
    check("rst_rdata", mem_out.mem_rdata, 32'd0);
    check("rst_msip", {31'b0, msip}, 32'd0);
    check("rst_mtip", {31'b0, mtip}, 32'd0);

    // Release, let 10 edges pass, capture on the next: mtime has counted 10.
    reset = 1'b0;
    repeat (10) @(negedge clock);
    rd("mtime_after_10", 32'h0200_BFF8, 32'd10);
    rd("mtimecmp_lo_rst", 32'h0200_4000, 32'hFFFF_FFFF);
    rd("mtimecmp_hi_rst", 32'h0200_4004, 32'hFFFF_FFFF);

    // msip: only bit 0 sticks, visible the cycle after capture.
    check("msip_before", {31'b0, msip}, 32'd0);
    req_start("msip_wr", 32'h0200_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, M_MODE);
    check("msip_next_cycle", {31'b0, msip}, 32'd1);
    req_end("msip_wr");
    rd("msip_rd", 32'h0200_0000, 32'h0000_0001);

    // Timer: mtime low <- 0 at edge E, mtimecmp = 0x20 written by E+4.
    wr("mtime_lo_zero", 32'h0200_BFF8, 32'd0, 4'hF);
    wr("cmp_hi_zero", 32'h0200_4004, 32'd0, 4'hF);
    wr("cmp_lo_20", 32'h0200_4000, 32'h20, 4'hF);
    check("mtip_early", {31'b0, mtip}, 32'd0);
    repeat (27) @(negedge clock);
    check("mtip_at_reach", {31'b0, mtip}, 32'd0);
    @(negedge clock);
    check("mtip_rise", {31'b0, mtip}, 32'd1);

    // Raising mtimecmp high clears mtip two edges after the write.
    req_start("cmp_hi_one", 32'h0200_4004, 32'd1, 4'hF, 1'b0, M_MODE);
    check("mtip_still_set", {31'b0, mtip}, 32'd1);
    req_end("cmp_hi_one");
    check("mtip_cleared", {31'b0, mtip}, 32'd0);

    // Wrap: all ones after the low write, 0 one edge later, read on the next edge.
    wr("mtime_hi_ones", 32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF);
    wr("mtime_lo_ones", 32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF);
    rd("mtime_lo_wrap", 32'h0200_BFF8, 32'd0);
    rd("mtime_hi_wrap", 32'h0200_BFFC, 32'd0);
    // Pre-edge low is 4; byte 1 becomes AB with no tick, one tick before the read.
    wr("mtime_byte", 32'h0200_BFF8, 32'h0000_AB00, 4'b0010);
    rd("mtime_lo_merged", 32'h0200_BFF8, 32'h0000_AB05);
    rd("mtime_hi_kept", 32'h0200_BFFC, 32'd0);

    // Error cases: no write, rdata 0.
    bad("misaligned", 32'h0200_0002, 32'd0, 4'hF, 1'b0, M_MODE);
    check("misaligned_msip", {31'b0, msip}, 32'd1);
    bad("unmapped", 32'h0200_1000, 32'd0, 4'h0, 1'b0, M_MODE);
    bad("instr", 32'h0200_0000, 32'd0, 4'hF, 1'b1, M_MODE);
    check("instr_msip", {31'b0, msip}, 32'd1);
    bad("umode", 32'h0200_4000, 32'd0, 4'h0, 1'b0, 2'b00);
    bad("umode_wr", 32'h0200_0000, 32'd0, 4'hF, 1'b0, 2'b00);
    check("umode_msip", {31'b0, msip}, 32'd1);
    bad("outside", 32'h0300_4000, 32'd0, 4'h0, 1'b0, M_MODE);
    rd("cmp_lo_kept", 32'h0200_4000, 32'h20);

    // Back-to-back with mem_valid held high.
    mem_in.mem_valid = 1'b1;
    mem_in.mem_instr = 1'b0;
    mem_in.mem_mode  = M_MODE;
    mem_in.mem_addr  = 32'h0200_4004;
    mem_in.mem_wdata = 32'd0;
    mem_in.mem_wstrb = 4'h0;
    @(posedge clock);
    @(negedge clock);
    check("b2b_ready1", {31'b0, mem_out.mem_ready}, 32'd1);
    check("b2b_rdata1", mem_out.mem_rdata, 32'd1);
    mem_in.mem_addr = 32'h0200_4000;
    @(posedge clock);
    @(negedge clock);
    check("b2b_gap", {31'b0, mem_out.mem_ready}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("b2b_ready2", {31'b0, mem_out.mem_ready}, 32'd1);
    check("b2b_rdata2", mem_out.mem_rdata, 32'h20);

    // Reset during RESP drops mem_ready without waiting for a clock edge.
    #2;
    reset = 1'b1;
    mem_in.mem_valid = 1'b0;
    #1;
    check("rst_async_ready", {31'b0, mem_out.mem_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", {31'b0, mem_out.mem_ready}, 32'd0);
    check("post_rst_msip", {31'b0, msip}, 32'd0);
    rd("post_rst_cmp", 32'h0200_4000, 32'hFFFF_FFFF);
    rd("post_rst_msip_rd", 32'h0200_0000, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
